btn_click_classifier: RTL and testbench

BTN_CLICK_CLASSIFIER -- requirements
Module: btn_click_classifier

---
 rtl/btn_click_classifier.sv | 100 ++++++++++
 tb/tb_btn_click_classifier.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/btn_click_classifier.sv
// Classifies a debounced button into single-click, double-click and long-press pulses.
// One shared counter times both the hold of the first press and the release gap.
module btn_click_classifier #(
    parameter int LONG_CYCLES = 50000000,
    parameter int GAP_CYCLES  = 25000000,
    parameter int CNT_W       = 27
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN,
    output logic SINGLE,
    output logic DOUBLE,
    output logic LONG,
    output logic BUSY
);

    typedef enum logic [2:0] {IDLE, PRESSED, WAIT_GAP, SECOND, HELD} state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             btn_q;
    logic             rise;
    logic             single_nxt, double_nxt, long_nxt;

    assign rise = BTN & ~btn_q;
    assign BUSY = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end
            end
            PRESSED: begin
                if (BTN) begin
                    if (cnt == LONG_LAST) begin
                        long_nxt  = 1'b1;
                        state_nxt = HELD;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else begin
                    state_nxt = WAIT_GAP;
                    cnt_nxt   = '0;
                end
            end
            WAIT_GAP: begin
                // A re-press wins over gap expiry on the same edge.
                if (BTN) begin
                    state_nxt = SECOND;
                end else if (cnt == GAP_LAST) begin
                    single_nxt = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SECOND: begin
                if (!BTN) begin
                    double_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            HELD: begin
                if (!BTN) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // btn_q resets high so a button held through reset release is not seen as a press.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            btn_q  <= 1'b1;
            SINGLE <= 1'b0;
            DOUBLE <= 1'b0;
            LONG   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            btn_q  <= BTN;
            SINGLE <= single_nxt;
            DOUBLE <= double_nxt;
            LONG   <= long_nxt;
        end
    end

endmodule

// File: tb/tb_btn_click_classifier.sv
// Randomized bench for btn_click_classifier: a run-length gesture model predicts
// pulse type and edge index into a scoreboard; a negedge monitor pops and compares.
module tb_btn_click_classifier;

    localparam int L = 8;
    localparam int G = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic BTN = 1'b0;
    logic SINGLE, DOUBLE, LONG, BUSY;

    btn_click_classifier #(.LONG_CYCLES(L), .GAP_CYCLES(G), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .BTN(BTN),
        .SINGLE(SINGLE), .DOUBLE(DOUBLE), .LONG(LONG), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct { int kind; int cyc; } exp_t;   // kind: 0 single, 1 double, 2 long
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    // Gesture model: lengths of the first high run, the following low run, and
    // whether a second press has begun, measured in sampled edges.
    bit active, held, second, prev;
    int run1, gap;

    function automatic void push(int kind, int cyc);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc;
        sb.push_back(e);
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            active = 0; held = 0; second = 0; prev = 1; run1 = 0; gap = 0;
            sb.delete();
        end else begin
            edge_cnt++;
            if (!active) begin
                if (BTN && !prev) begin
                    active = 1; held = 0; second = 0; run1 = 1; gap = 0;
                end
            end else if (held) begin
                if (!BTN) active = 0;
            end else if (second) begin
                if (!BTN) begin push(1, edge_cnt); active = 0; end
            end else if (gap == 0) begin
                if (BTN) begin
                    run1++;
                    if (run1 == L + 1) begin push(2, edge_cnt); held = 1; end
                end else begin
                    gap = 1;
                end
            end else begin
                if (BTN) second = 1;
                else begin
                    gap++;
                    if (gap == G + 1) begin push(0, edge_cnt); active = 0; end
                end
            end
            prev = BTN;
        end
    end

    always @(negedge CLK) begin
        if (RESET) begin
            total++;
            if (BUSY !== active) begin
                bad++;
                $display("FAIL busy edge=%0d got=%b want=%b", edge_cnt, BUSY, active);
            end
            if (sb.size() > 0 && sb[0].cyc < edge_cnt) begin
                total++; bad++;
                $display("FAIL missed_pulse kind=%0d want_edge=%0d now=%0d", sb[0].kind, sb[0].cyc, edge_cnt);
                void'(sb.pop_front());
            end
            if (SINGLE || DOUBLE || LONG) begin
                int k;
                exp_t e;
                k = SINGLE ? 0 : (DOUBLE ? 1 : 2);
                total++;
                if ((int'(SINGLE) + int'(DOUBLE) + int'(LONG)) != 1) begin
                    bad++;
                    $display("FAIL exclusive edge=%0d got=%b%b%b want=one-hot", edge_cnt, SINGLE, DOUBLE, LONG);
                end else if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse kind=%0d edge=%0d want=none", k, edge_cnt);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != k || e.cyc != edge_cnt) begin
                        bad++;
                        $display("FAIL pulse got kind=%0d edge=%0d want kind=%0d edge=%0d", k, edge_cnt, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    task automatic drive(input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1 BTN = b;
        end
    endtask

    task automatic do_reset(input int hold);
        @(posedge CLK);
        #1 RESET = 1'b0;
        sb.delete();
        #1;
        total++;
        if ({SINGLE, DOUBLE, LONG, BUSY} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b%b%b%b want=0000", SINGLE, DOUBLE, LONG, BUSY);
        end
        repeat (hold) @(posedge CLK);
        #1 RESET = 1'b1;
    endtask

    initial begin
        do_reset(3);
        drive(0, 3);
        // single click
        drive(1, 3); drive(0, 10);
        // double click
        drive(1, 3); drive(0, 2); drive(1, 3); drive(0, 6);
        // long press held well past threshold
        drive(1, 20); drive(0, 4);
        // re-press on the gap-expiry edge
        drive(1, 3); drive(0, 4); drive(1, 2); drive(0, 6);
        // gap one edge longer: single, then a separate gesture
        drive(1, 3); drive(0, 5); drive(1, 2); drive(0, 8);
        // long second press still a double
        drive(1, 2); drive(0, 1); drive(1, 15); drive(0, 4);
        // press exactly one short of long
        drive(1, 8); drive(0, 8);
        // button held across reset release
        drive(1, 1); do_reset(2); drive(1, 6); drive(0, 2); drive(1, 3); drive(0, 8);
        // reset in the middle of the gap
        drive(1, 3); drive(0, 2); do_reset(2); drive(0, 10);
        // random level runs
        for (int s = 0; s < 300; s++) begin
            drive(s[0] ? 1'b1 : 1'b0, $urandom_range(1, 12));
            if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 3));
        end
        drive(0, 12);
        @(negedge CLK);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover_expect got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
